// File: rtl/mem_sram_ctrl.sv
// MEM-stage controller that serves word loads/stores from a narrower asynchronous SRAM.
// Each access is split into SRAM_DW-wide beats, and ready is held low until the word is complete.
module mem_sram_ctrl #(
  parameter int WORD_W      = 32,
  parameter int SRAM_DW     = 16,
  parameter int SRAM_AW     = 18,
  parameter int WAIT_CYCLES = 5,
  parameter int ADDR_BASE   = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rd_en,
  input  logic               wr_en,
  input  logic [WORD_W-1:0]  address,
  input  logic [WORD_W-1:0]  write_data,
  output logic [WORD_W-1:0]  read_data,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [SRAM_DW-1:0] sram_dq_out,
  input  logic [SRAM_DW-1:0] sram_dq_in,
  output logic               sram_dq_oe,
  output logic               sram_we_n
);

  localparam int BEATS = WORD_W / SRAM_DW;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int WCW   = $clog2(WAIT_CYCLES);
  localparam int SH    = $clog2(WORD_W / 8);
  localparam logic [WORD_W-1:0] BASE      = WORD_W'(ADDR_BASE);
  localparam logic [BW-1:0]     LAST_BEAT = BW'(BEATS - 1);
  localparam logic [WCW-1:0]    LAST_WAIT = WCW'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2} state_t;

  state_t            state;
  logic              op_rd;
  logic [WORD_W-1:0] word_idx;
  logic [WORD_W-1:0] wdata;
  logic [BW-1:0]     beat_cnt;
  logic [WCW-1:0]    wait_cnt;
  logic [WORD_W-1:0] req_idx;

  assign req_idx = (address - BASE) >> SH;

  // {word, beat} concatenation; addresses past the SRAM wrap modulo 2^SRAM_AW.
  function automatic logic [SRAM_AW-1:0] beat_addr(input logic [WORD_W-1:0] idx,
                                                   input logic [BW-1:0] beat);
    logic [SRAM_AW+WORD_W+BW-1:0] full;
    full = {{SRAM_AW{1'b0}}, idx, beat};
    return full[SRAM_AW-1:0];
  endfunction

  function automatic logic [SRAM_DW-1:0] slice(input logic [WORD_W-1:0] w,
                                               input logic [BW-1:0] beat);
    return w[beat*SRAM_DW +: SRAM_DW];
  endfunction

  // The freeze must assert in the request cycle itself, so the IDLE term is combinational.
  always_comb begin
    ready = 1'b0;
    case (state)
      IDLE:    ready = ~(rd_en | wr_en);
      DONE:    ready = 1'b1;
      default: ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      op_rd       <= 1'b0;
      word_idx    <= '0;
      wdata       <= '0;
      beat_cnt    <= '0;
      wait_cnt    <= '0;
      read_data   <= '0;
      sram_addr   <= '0;
      sram_dq_out <= '0;
      sram_dq_oe  <= 1'b0;
      sram_we_n   <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (rd_en | wr_en) begin
            state       <= ACCESS;
            op_rd       <= rd_en;
            word_idx    <= req_idx;
            wdata       <= write_data;
            beat_cnt    <= '0;
            wait_cnt    <= '0;
            sram_addr   <= beat_addr(req_idx, '0);
            sram_dq_out <= slice(write_data, '0);
            sram_dq_oe  <= ~rd_en;
            sram_we_n   <= rd_en;
          end
        end
        ACCESS: begin
          if (wait_cnt == LAST_WAIT) begin
            if (op_rd) read_data[beat_cnt*SRAM_DW +: SRAM_DW] <= sram_dq_in;
            wait_cnt <= '0;
            if (beat_cnt == LAST_BEAT) begin
              state      <= DONE;
              sram_dq_oe <= 1'b0;
              sram_we_n  <= 1'b1;
            end else begin
              beat_cnt    <= beat_cnt + 1'b1;
              sram_addr   <= beat_addr(word_idx, beat_cnt + 1'b1);
              sram_dq_out <= slice(wdata, beat_cnt + 1'b1);
              sram_we_n   <= op_rd;
            end
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
            // we_n rises for the final cycle of the beat; that edge commits the write.
            if (wait_cnt + 1'b1 == LAST_WAIT) sram_we_n <= 1'b1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
